// File: rtl/systolic_layer_controller.sv
// -----------------------------------------------------------------------------
// systolic_layer_controller
//
// Purpose:
//   Sequences one convolution layer on an S x S systolic PE array. The layer
//   geometry is latched at start: kernel size K, channels C, filters F and
//   output tiles per filter group T. For each group of up to S filters the
//   controller runs these phases:
//     LOAD_WGT - stream L = K*K*C weights into the array and fill IFM bank 0
//     TILE     - one compute window per tile. The next tile is prefetched
//                into the other IFM bank (ping-pong) and the previous tile's
//                results are written out while the current tile computes.
//     WRITE    - drain the results of the last tile of the group
//   DONE pulses once after the last group. A stall input freezes the
//   sequencing, and the controller reports a bad configuration at start.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               launch a layer (sampled only in IDLE)
//   stall               freeze sequencing; enable strobes are forced low
//   cfg_kernel_size     K
//   cfg_no_channel      C
//   cfg_no_filter       F
//   cfg_no_tile         T
//   load_wgt/load_ifm   weight / IFM buffer read-push enables
//   ifm_bank_wr/_rd     IFM register-file bank being filled / feeding array
//   ifm_shift_en[1:0]   per-bank IFM shift enable
//   wgt_shift_en[S-1:0] per-column weight shift enable (skewed by column)
//   wgt_col_valid       columns holding a real filter in the current group
//   reset_pe            clear PE accumulators
//   write_out_en        push one result row to the output buffer
//   busy, done          status: not idle / one-cycle end-of-layer pulse
//   cfg_error           one-cycle pulse when start sees an illegal config
// -----------------------------------------------------------------------------
module systolic_layer_controller #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int MAX_KERNEL    = 7,
  parameter int MAX_CHANNEL   = 64,
  parameter int MAX_FILTER    = 1024,
  parameter int MAX_TILE      = 16384,
  localparam int KW = $clog2(MAX_KERNEL + 1),
  localparam int CW = $clog2(MAX_CHANNEL + 1),
  localparam int FW = $clog2(MAX_FILTER + 1),
  localparam int TW = $clog2(MAX_TILE + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stall,
  input  logic [KW-1:0]            cfg_kernel_size,
  input  logic [CW-1:0]            cfg_no_channel,
  input  logic [FW-1:0]            cfg_no_filter,
  input  logic [TW-1:0]            cfg_no_tile,
  output logic                     load_wgt,
  output logic                     load_ifm,
  output logic                     ifm_bank_wr,
  output logic                     ifm_bank_rd,
  output logic [1:0]               ifm_shift_en,
  output logic [SYSTOLIC_SIZE-1:0] wgt_shift_en,
  output logic [SYSTOLIC_SIZE-1:0] wgt_col_valid,
  output logic                     reset_pe,
  output logic                     write_out_en,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_error
);

  localparam int S = SYSTOLIC_SIZE;
  // Largest count value is the compute window L+2S-1 at maximum geometry.
  localparam int CNT_W = $clog2(MAX_KERNEL * MAX_KERNEL * MAX_CHANNEL + 2 * S + 1);
  localparam int GRP_W = $clog2((MAX_FILTER + S - 1) / S + 1);
  localparam logic [31:0]      S_U    = 32'(S);
  localparam logic [CNT_W-1:0] S_CNT  = CNT_W'(S);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(S - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WGT,
    TILE,
    WRITE,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TW-1:0]    tile_q;
  logic [GRP_W-1:0] group_q;
  logic             bank_wr_q;
  logic             cfg_err_q;

  // Latched layer geometry.
  logic [CNT_W-1:0] len_q;        // L = K*K*C
  logic [CNT_W-1:0] cmp_q;        // compute window L + 2S - 1
  logic [GRP_W-1:0] ngrp_q;       // G = ceil(F / S)
  logic [TW-1:0]    ntile_q;      // T
  logic [S-1:0]     last_mask_q;  // valid columns of the final group

  // Configuration decode, evaluated on the inputs while idle.
  logic [31:0]      k_w, c_w, f_w, t_w, rem_w;
  logic             cfg_ok;
  logic [CNT_W-1:0] len_d, cmp_d;
  logic [GRP_W-1:0] ngrp_d;
  logic [S-1:0]     last_mask_d;

  assign k_w   = 32'(cfg_kernel_size);
  assign c_w   = 32'(cfg_no_channel);
  assign f_w   = 32'(cfg_no_filter);
  assign t_w   = 32'(cfg_no_tile);
  assign rem_w = f_w % S_U;

  assign cfg_ok = (k_w != 32'd0) && (k_w <= 32'(MAX_KERNEL))
               && (c_w != 32'd0) && (c_w <= 32'(MAX_CHANNEL))
               && (f_w != 32'd0) && (f_w <= 32'(MAX_FILTER))
               && (t_w != 32'd0) && (t_w <= 32'(MAX_TILE));

  assign len_d  = CNT_W'(k_w * k_w * c_w);
  assign cmp_d  = CNT_W'(k_w * k_w * c_w + 2 * S_U - 32'd1);
  assign ngrp_d = GRP_W'((f_w + S_U - 32'd1) / S_U);

  logic tile_last;
  logic grp_last;
  logic [S-1:0] tile_wgt_en;

  assign tile_last = (tile_q == ntile_q - TW'(1));
  assign grp_last  = (group_q == ngrp_q - GRP_W'(1));

  // Only the final group can be partial; elsewhere every column is a filter.
  assign wgt_col_valid = (state_q == IDLE) ? '0 :
                         grp_last          ? last_mask_q : '1;

  for (genvar gi = 0; gi < S; gi++) begin : g_col
    // A remainder of zero means the final group is full as well.
    assign last_mask_d[gi] = (rem_w == 32'd0) || (32'(gi) < rem_w);
    // Column gi sees its weights gi cycles after column 0 (array skew).
    assign tile_wgt_en[gi] = (cnt_q >= CNT_W'(gi)) && (cnt_q < len_q + CNT_W'(gi))
                          && wgt_col_valid[gi];
  end

  // Sequencer: state, counters, bank select and latched configuration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tile_q      <= '0;
      group_q     <= '0;
      bank_wr_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      len_q       <= '0;
      cmp_q       <= '0;
      ngrp_q      <= '0;
      ntile_q     <= '0;
      last_mask_q <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      if (!stall) begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                len_q       <= len_d;
                cmp_q       <= cmp_d;
                ngrp_q      <= ngrp_d;
                ntile_q     <= cfg_no_tile;
                last_mask_q <= last_mask_d;
                state_q     <= LOAD_WGT;
                cnt_q       <= '0;
                group_q     <= '0;
                bank_wr_q   <= 1'b0;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          LOAD_WGT: begin
            // Two extra cycles after the L loads let the pipeline settle.
            if (cnt_q == len_q + CNT_W'(1)) begin
              state_q   <= TILE;
              cnt_q     <= '0;
              tile_q    <= '0;
              bank_wr_q <= 1'b1;  // array now reads bank 0
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          TILE: begin
            if (cnt_q == cmp_q - CNT_W'(1)) begin
              cnt_q     <= '0;
              bank_wr_q <= ~bank_wr_q;
              tile_q    <= tile_q + TW'(1);
              if (tile_last) begin
                state_q <= WRITE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          WRITE: begin
            if (cnt_q == S_LAST) begin
              cnt_q   <= '0;
              group_q <= group_q + GRP_W'(1);
              if (!grp_last) begin
                state_q   <= LOAD_WGT;
                bank_wr_q <= 1'b0;
              end else begin
                state_q <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DONE: begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            group_q   <= '0;
            bank_wr_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ifm_bank_wr = bank_wr_q;
  assign ifm_bank_rd = ~bank_wr_q;
  assign busy        = (state_q != IDLE);
  assign cfg_error   = cfg_err_q;

  // Output decode of state and count. Stall only masks the enable strobes;
  // because the count holds, each masked strobe is issued once stall drops.
  always_comb begin
    load_wgt     = 1'b0;
    load_ifm     = 1'b0;
    ifm_shift_en = 2'b00;
    wgt_shift_en = '0;
    reset_pe     = 1'b0;
    write_out_en = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      LOAD_WGT: begin
        if (cnt_q < len_q) begin
          load_wgt        = 1'b1;
          load_ifm        = 1'b1;
          wgt_shift_en    = '1;
          ifm_shift_en[0] = 1'b1;
        end
      end
      TILE: begin
        wgt_shift_en = tile_wgt_en;
        if (cnt_q < len_q + S_CNT) begin
          ifm_shift_en[ifm_bank_rd] = 1'b1;
        end
        // Prefetch the next tile into the idle bank unless this is the last.
        if (!tile_last && (cnt_q < len_q)) begin
          load_ifm                  = 1'b1;
          ifm_shift_en[ifm_bank_wr] = 1'b1;
        end
        // Previous tile's results drain while this tile computes.
        write_out_en = (tile_q != '0) && (cnt_q < S_CNT);
        reset_pe     = (cnt_q == cmp_q - CNT_W'(1));
      end
      WRITE: begin
        write_out_en = 1'b1;
        reset_pe     = (cnt_q == S_LAST);
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
    if (stall) begin
      load_wgt     = 1'b0;
      load_ifm     = 1'b0;
      ifm_shift_en = 2'b00;
      wgt_shift_en = '0;
      write_out_en = 1'b0;
      done         = 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_layer_controller.sv
// -----------------------------------------------------------------------------
// tb_systolic_layer_controller
//
// Self-checking bench. For each layer a reference trace is built from the
// phase rules (weight load, per-tile compute windows, write-out, done) as a
// queue of expected output vectors, one per unstalled cycle. A stalled cycle
// re-uses the head of the queue with its enable strobes cleared.
// -----------------------------------------------------------------------------
module tb_systolic_layer_controller;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [2:0]  cfg_kernel_size;
  logic [6:0]  cfg_no_channel;
  logic [10:0] cfg_no_filter;
  logic [14:0] cfg_no_tile;
  logic        load_wgt, load_ifm, ifm_bank_wr, ifm_bank_rd;
  logic [1:0]  ifm_shift_en;
  logic [S-1:0] wgt_shift_en, wgt_col_valid;
  logic        reset_pe, write_out_en, busy, done, cfg_error;

  systolic_layer_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stall           (stall),
    .cfg_kernel_size (cfg_kernel_size),
    .cfg_no_channel  (cfg_no_channel),
    .cfg_no_filter   (cfg_no_filter),
    .cfg_no_tile     (cfg_no_tile),
    .load_wgt        (load_wgt),
    .load_ifm        (load_ifm),
    .ifm_bank_wr     (ifm_bank_wr),
    .ifm_bank_rd     (ifm_bank_rd),
    .ifm_shift_en    (ifm_shift_en),
    .wgt_shift_en    (wgt_shift_en),
    .wgt_col_valid   (wgt_col_valid),
    .reset_pe        (reset_pe),
    .write_out_en    (write_out_en),
    .busy            (busy),
    .done            (done),
    .cfg_error       (cfg_error)
  );

  always #5 clk = ~clk;

  // Vector layout: {load_wgt, load_ifm, bank_wr, bank_rd, ifm_shift[1:0],
  //                 wgt_shift[15:0], reset_pe, write_out, busy, done, cfg_error}
  localparam logic [26:0] IDLE_V     = {4'b0001, 23'd0};
  localparam logic [26:0] STALL_MASK = {1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'hFFFF,
                                        1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  typedef struct {
    logic [26:0] v;
    logic [15:0] cv;
    bit          cv_chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] obs();
    return {load_wgt, load_ifm, ifm_bank_wr, ifm_bank_rd, ifm_shift_en, wgt_shift_en,
            reset_pe, write_out_en, busy, done, cfg_error};
  endfunction

  function automatic logic [26:0] pk(input logic lw, input logic li, input logic bw,
                                     input logic br, input logic [1:0] is,
                                     input logic [15:0] ws, input logic rp,
                                     input logic wo, input logic by, input logic dn,
                                     input logic ce);
    return {lw, li, bw, br, is, ws, rp, wo, by, dn, ce};
  endfunction

  task automatic push(input logic [26:0] v, input logic [15:0] cv, input bit chk);
    exp_t e;
    e.v = v;
    e.cv = cv;
    e.cv_chk = chk;
    exp_q.push_back(e);
  endtask

  // Expected trace of a whole layer from the phase rules.
  task automatic build_model(input int k, input int c, input int f, input int t);
    int l, cmp, g, rem;
    logic [15:0] cv, ws;
    logic [1:0]  is;
    logic        rd, li, en, trd;
    l   = k * k * c;
    cmp = l + 2 * S - 1;
    g   = (f + S - 1) / S;
    rem = f % S;
    trd = t[0];  // bank feeding the array after T swaps
    exp_q.delete();
    for (int gr = 0; gr < g; gr++) begin
      cv = (gr == g - 1 && rem != 0) ? 16'((1 << rem) - 1) : 16'hFFFF;
      for (int n = 0; n < l + 2; n++) begin
        en = (n < l);
        push(pk(en, en, 1'b0, 1'b1, en ? 2'b01 : 2'b00, en ? 16'hFFFF : 16'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0), cv, 1'b1);
      end
      for (int ti = 0; ti < t; ti++) begin
        rd = ti[0];
        for (int n = 0; n < cmp; n++) begin
          is = 2'b00;
          li = 1'b0;
          if (n < l + S) is[rd] = 1'b1;
          if (ti < t - 1 && n < l) begin
            is[~rd] = 1'b1;
            li = 1'b1;
          end
          for (int i = 0; i < S; i++) ws[i] = (n >= i) && (n < l + i) && cv[i];
          push(pk(1'b0, li, ~rd, rd, is, ws, n == cmp - 1, (ti > 0) && (n < S),
                  1'b1, 1'b0, 1'b0), cv, 1'b1);
        end
      end
      for (int n = 0; n < S; n++)
        push(pk(1'b0, 1'b0, ~trd, trd, 2'b00, 16'h0, n == S - 1, 1'b1, 1'b1, 1'b0, 1'b0),
             cv, 1'b1);
    end
    push(pk(1'b0, 1'b0, ~trd, trd, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 16'h0, 1'b0);
  endtask

  // Start a layer and follow the reference trace. Stall is driven inside the
  // window [st_from, st_from+st_len) and also at random with st_pct percent;
  // with st_pct>0 start and cfg are also toggled while busy (must be ignored).
  task automatic run_layer(input int k, input int c, input int f, input int t,
                           input int st_from, input int st_len, input int st_pct,
                           output int done_cyc, output int n_done, output int n_wr);
    exp_t e;
    logic [26:0] ev;
    logic stl;
    int cyc;
    build_model(k, c, f, t);
    @(posedge clk); #1;
    cfg_kernel_size = 3'(k);
    cfg_no_channel  = 7'(c);
    cfg_no_filter   = 11'(f);
    cfg_no_tile     = 15'(t);
    start = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    check_eq("pre_start", 64'(obs()), 64'(IDLE_V));
    cyc = 0;
    done_cyc = -1;
    n_done = 0;
    n_wr = 0;
    while (exp_q.size() > 0) begin
      cyc++;
      @(posedge clk); #1;
      start = 1'b0;
      if (st_pct > 0) begin
        start           = 1'($urandom_range(0, 1));
        cfg_kernel_size = 3'($urandom);
        cfg_no_channel  = 7'($urandom);
        cfg_no_filter   = 11'($urandom);
        cfg_no_tile     = 15'($urandom);
      end
      stl = (cyc >= st_from && cyc < st_from + st_len) ||
            (st_pct > 0 && $urandom_range(0, 99) < st_pct);
      stall = stl;
      @(negedge clk);
      e  = exp_q[0];
      ev = e.v;
      if (stl) ev = ev & ~STALL_MASK;
      else     void'(exp_q.pop_front());
      check_eq($sformatf("vec k%0d c%0d f%0d t%0d cyc%0d", k, c, f, t, cyc),
               64'(obs()), 64'(ev));
      if (e.cv_chk)
        check_eq($sformatf("col_valid cyc%0d", cyc), 64'(wgt_col_valid), 64'(e.cv));
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (write_out_en) n_wr++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check_eq("post_idle", 64'(obs()), 64'(IDLE_V));
    check_eq("post_idle_colv", 64'(wgt_col_valid), 64'd0);
  endtask

  task automatic cfg_err_case(input int k, input int c, input int f, input int t);
    @(posedge clk); #1;
    cfg_kernel_size = 3'(k);
    cfg_no_channel  = 7'(c);
    cfg_no_filter   = 11'(f);
    cfg_no_tile     = 15'(t);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq($sformatf("cfg_err k%0d c%0d f%0d t%0d", k, c, f, t), 64'(obs()),
             64'(pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    @(negedge clk);
    check_eq("cfg_err_clear", 64'(obs()), 64'(IDLE_V));
  endtask

  initial begin
    int dc, nd, nw, rnd;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    cfg_kernel_size = '0;
    cfg_no_channel  = '0;
    cfg_no_filter   = '0;
    cfg_no_tile     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_vec", 64'(obs()), 64'(IDLE_V));
    check_eq("reset_colv", 64'(wgt_col_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reference layer: phase boundaries and write-out count.
    run_layer(3, 3, 16, 2, 0, 0, 0, dc, nd, nw);
    check_eq("case1_done_cycle", 64'(dc), 64'd162);
    check_eq("case1_write_cycles", 64'(nw), 64'd32);
    check_eq("case1_done_count", 64'(nd), 64'd1);

    // Partial final filter group, single tile.
    run_layer(3, 3, 20, 1, 0, 0, 0, dc, nd, nw);
    check_eq("f20_done_count", 64'(nd), 64'd1);
    check_eq("f20_write_cycles", 64'(nw), 64'd32);

    // Five stalled cycles inside the first tile.
    run_layer(3, 3, 16, 2, 60, 5, 0, dc, nd, nw);
    check_eq("stall_done_cycle", 64'(dc), 64'd167);
    check_eq("stall_write_cycles", 64'(nw), 64'd32);

    // Illegal configurations.
    cfg_err_case(3, 0, 16, 2);
    cfg_err_case(0, 3, 16, 2);
    cfg_err_case(3, 65, 16, 2);
    cfg_err_case(3, 3, 1025, 2);
    cfg_err_case(3, 3, 16, 0);
    cfg_err_case(3, 3, 16, 16385);

    // Randomized layers with random stalls and ignored start/cfg while busy.
    for (int r = 0; r < 8; r++) begin
      rnd = int'($urandom_range(5, 25));
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
                0, 0, rnd, dc, nd, nw);
      check_eq($sformatf("rand%0d_done_count", r), 64'(nd), 64'd1);
    end

    // Reset in the middle of a tile aborts without done.
    @(posedge clk); #1;
    cfg_kernel_size = 3'd3;
    cfg_no_channel  = 7'd3;
    cfg_no_filter   = 11'd16;
    cfg_no_tile     = 15'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midreset_vec", 64'(obs()), 64'(IDLE_V));
    nd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check_eq("midreset_no_activity", 64'(nd), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
